// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU opcodes, forward-select codes,
// the ID/EX control bundle, its bubble value and the forward-pick rule.
package pipe_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src;
        logic [3:0] alu_cntrl;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '{
        valid:      1'b0,
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        branch:     1'b0,
        alu_src:    1'b0,
        alu_cntrl:  ALU_ADD
    };

    // EX/MEM is the younger producer, so it wins; x0 is hardwired zero.
    function automatic fwd_sel_e fwd_pick(
        input logic [4:0] rs,
        input logic       exmem_reg_write,
        input logic [4:0] exmem_rd,
        input logic       memwb_reg_write,
        input logic [4:0] memwb_rd
    );
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rs)
            return FWD_EXMEM;
        if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs)
            return FWD_MEMWB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational forward-select for two source registers.
// Ports: rs1/rs2 addresses, EX/MEM and MEM/WB write-back info -> fwd1/fwd2.
module forward_unit
    import pipe_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       exmem_reg_write,
    input  logic [4:0] exmem_rd,
    input  logic       memwb_reg_write,
    input  logic [4:0] memwb_rd,
    output fwd_sel_e   fwd1,
    output fwd_sel_e   fwd2
);

    assign fwd1 = fwd_pick(rs1, exmem_reg_write, exmem_rd,
                           memwb_reg_write, memwb_rd);
    assign fwd2 = fwd_pick(rs2, exmem_reg_write, exmem_rd,
                           memwb_reg_write, memwb_rd);

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with operand forwarding and load-use hazard detection.
// Ports: id_* decoded fields in, stall/flush, EX/MEM + MEM/WB forward
// sources in; ALU operands, store data, EX control and hazard_stall out.
module ex_operand_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rs1_data,
    input  logic [WIDTH-1:0] id_rs2_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic [4:0]       id_rd_addr,
    input  logic [3:0]       id_alu_cntrl,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_branch,
    input  logic             stall,
    input  logic             flush,
    input  logic             exmem_reg_write,
    input  logic [4:0]       exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [4:0]       memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic             ex_valid,
    output logic [3:0]       alu_cntrl,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_branch,
    output logic             hazard_stall
);

    ctrl_t            ctrl_q;
    ctrl_t            id_ctrl;
    logic [WIDTH-1:0] rs1_data_q;
    logic [WIDTH-1:0] rs2_data_q;
    logic [WIDTH-1:0] imm_q;
    logic [4:0]       rs1_addr_q;
    logic [4:0]       rs2_addr_q;
    logic [4:0]       rd_q;
    fwd_sel_e         fwd1;
    fwd_sel_e         fwd2;
    logic [WIDTH-1:0] rs1_fwd;
    logic [WIDTH-1:0] rs2_fwd;

    always_comb begin
        id_ctrl = '{
            valid:      id_valid,
            reg_write:  id_reg_write,
            mem_read:   id_mem_read,
            mem_write:  id_mem_write,
            mem_to_reg: id_mem_to_reg,
            branch:     id_branch,
            alu_src:    id_alu_src,
            alu_cntrl:  id_alu_cntrl
        };
    end

    // rs2 is compared even for I-type; a spurious stall costs one cycle.
    assign hazard_stall = ctrl_q.valid & ctrl_q.mem_read
                        & (rd_q != 5'd0) & id_valid
                        & ((rd_q == id_rs1_addr) | (rd_q == id_rs2_addr));

    // Bubbles also zero the rs addresses so no forwarding can match them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= BUBBLE_CTRL;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_q       <= '0;
        end else if (flush || (!stall && hazard_stall)) begin
            ctrl_q     <= BUBBLE_CTRL;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_q       <= '0;
        end else if (!stall) begin
            ctrl_q     <= id_ctrl;
            rs1_data_q <= id_rs1_data;
            rs2_data_q <= id_rs2_data;
            imm_q      <= id_imm;
            rs1_addr_q <= id_rs1_addr;
            rs2_addr_q <= id_rs2_addr;
            rd_q       <= id_rd_addr;
        end
    end

    forward_unit u_fwd (
        .rs1             (rs1_addr_q),
        .rs2             (rs2_addr_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .fwd1            (fwd1),
        .fwd2            (fwd2)
    );

    always_comb begin
        rs1_fwd = rs1_data_q;
        unique case (fwd1)
            FWD_EXMEM: rs1_fwd = exmem_result;
            FWD_MEMWB: rs1_fwd = memwb_result;
            default:   rs1_fwd = rs1_data_q;
        endcase
    end

    always_comb begin
        rs2_fwd = rs2_data_q;
        unique case (fwd2)
            FWD_EXMEM: rs2_fwd = exmem_result;
            FWD_MEMWB: rs2_fwd = memwb_result;
            default:   rs2_fwd = rs2_data_q;
        endcase
    end

    assign alu_in1       = rs1_fwd;
    assign alu_in2       = ctrl_q.alu_src ? imm_q : rs2_fwd;
    assign ex_store_data = rs2_fwd;
    assign ex_valid      = ctrl_q.valid;
    assign alu_cntrl     = ctrl_q.alu_cntrl;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_branch     = ctrl_q.branch;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: a reference model predicts
// outputs per step, expected values are queued and compared on output.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]  id_alu_cntrl;
    logic        id_alu_src, id_reg_write, id_mem_read;
    logic        id_mem_write, id_mem_to_reg, id_branch;
    logic        stall, flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid;
    logic [3:0]  alu_cntrl;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_mem_to_reg, ex_branch, hazard_stall;

    always #5 clk = ~clk;

    ex_operand_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_alu_cntrl(id_alu_cntrl), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_branch(id_branch), .stall(stall), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .memwb_result(memwb_result),
        .ex_valid(ex_valid), .alu_cntrl(alu_cntrl),
        .alu_in1(alu_in1), .alu_in2(alu_in2),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .hazard_stall(hazard_stall)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        valid;
        logic [3:0]  alu;
        logic [31:0] in1, in2, sd;
        logic [4:0]  rd;
        logic        rw, mr, mw, m2r, br, hz;
    } exp_t;

    exp_t sb[$];

    // reference model of the EX slot
    logic        m_valid, m_rw, m_mr, m_mw, m_m2r, m_br, m_src;
    logic [3:0]  m_alu;
    logic [31:0] m_rs1d, m_rs2d, m_imm;
    logic [4:0]  m_rs1a, m_rs2a, m_rd;

    function automatic logic [31:0] fwd(input logic [4:0] a,
                                        input logic [31:0] d);
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == a)
            return exmem_result;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == a)
            return memwb_result;
        return d;
    endfunction

    function automatic logic m_hz();
        return m_valid && m_mr && m_rd != 0 && id_valid &&
               (m_rd == id_rs1_addr || m_rd == id_rs2_addr);
    endfunction

    task automatic m_bubble();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
        m_br = 0; m_src = 0; m_alu = 4'b0010;
        m_rs1d = 0; m_rs2d = 0; m_imm = 0;
        m_rs1a = 0; m_rs2a = 0; m_rd = 0;
    endtask

    task automatic m_step();
        if (flush) m_bubble();
        else if (stall) ;
        else if (m_hz()) m_bubble();
        else begin
            m_valid = id_valid; m_rw = id_reg_write;
            m_mr = id_mem_read; m_mw = id_mem_write;
            m_m2r = id_mem_to_reg; m_br = id_branch;
            m_src = id_alu_src; m_alu = id_alu_cntrl;
            m_rs1d = id_rs1_data; m_rs2d = id_rs2_data;
            m_imm = id_imm; m_rs1a = id_rs1_addr;
            m_rs2a = id_rs2_addr; m_rd = id_rd_addr;
        end
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        e.valid = m_valid; e.alu = m_alu;
        e.in1 = fwd(m_rs1a, m_rs1d);
        e.sd = fwd(m_rs2a, m_rs2d);
        e.in2 = m_src ? m_imm : e.sd;
        e.rd = m_rd; e.rw = m_rw; e.mr = m_mr; e.mw = m_mw;
        e.m2r = m_m2r; e.br = m_br; e.hz = m_hz();
        return e;
    endfunction

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_valid"}, 32'(ex_valid), 32'(e.valid));
        check({tag, "_alu"}, 32'(alu_cntrl), 32'(e.alu));
        check({tag, "_in1"}, alu_in1, e.in1);
        check({tag, "_in2"}, alu_in2, e.in2);
        check({tag, "_sd"}, ex_store_data, e.sd);
        check({tag, "_rd"}, 32'(ex_rd), 32'(e.rd));
        check({tag, "_ctl"},
              32'({ex_reg_write, ex_mem_read, ex_mem_write,
                   ex_mem_to_reg, ex_branch}),
              32'({e.rw, e.mr, e.mw, e.m2r, e.br}));
        check({tag, "_hz"}, 32'(hazard_stall), 32'(e.hz));
    endtask

    task automatic tick(input string tag);
        m_step();
        sb.push_back(expect_now());
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic observe(input string tag);
        #1;
        sb.push_back(expect_now());
        compare(tag);
    endtask

    task automatic set_id(input logic v, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [3:0] op,
                          input logic src, input logic rw,
                          input logic mr, input logic mw,
                          input logic m2r, input logic br);
        id_valid = v; id_rs1_addr = a1; id_rs2_addr = a2;
        id_rd_addr = rd; id_rs1_data = d1; id_rs2_data = d2;
        id_imm = imm; id_alu_cntrl = op; id_alu_src = src;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
        id_mem_to_reg = m2r; id_branch = br;
    endtask

    task automatic no_fwd();
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    initial begin
        stall = 0; flush = 0;
        no_fwd();
        set_id(1, 1, 2, 3, 32'h1234, 32'h5678, 0, 4'b0110,
               0, 1, 0, 0, 0, 0);
        m_bubble();
        #12;
        observe("reset");
        check("reset_alu", 32'(alu_cntrl), 32'h2);
        @(negedge clk);
        rst = 0;

        // basic capture: add x3,x1,x2
        set_id(1, 1, 2, 3, 5, 7, 0, 4'b0010, 0, 1, 0, 0, 0, 0);
        tick("basic");
        check("basic_in1", alu_in1, 5);
        check("basic_in2", alu_in2, 7);
        check("basic_rd", 32'(ex_rd), 3);

        // forwarding priority on rs1 = x4
        set_id(1, 4, 2, 6, 32'h1, 32'h2, 0, 4'b0000, 0, 1, 0, 0, 0, 0);
        exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'hBB;
        tick("fwd_both");
        check("fwd_exmem_wins", alu_in1, 32'hAA);
        exmem_reg_write = 0;
        observe("fwd_memwb");
        check("fwd_memwb_only", alu_in1, 32'hBB);

        // x0 guard
        no_fwd();
        set_id(1, 0, 0, 7, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 0, 0);
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFFFF_FFFF;
        tick("x0");
        check("x0_in1", alu_in1, 0);
        check("x0_sd", ex_store_data, 0);

        // load-use: lw x5, 8(x1) then add x6,x5,x2
        no_fwd();
        set_id(1, 1, 0, 5, 32'h100, 0, 8, 4'b0010, 1, 1, 1, 0, 1, 0);
        tick("lw");
        check("lw_in2_imm", alu_in2, 8);
        set_id(1, 5, 2, 6, 32'hDEAD, 32'h3, 0, 4'b0010, 0, 1, 0, 0, 0, 0);
        observe("lu_detect");
        check("lu_hz_on", 32'(hazard_stall), 1);
        exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'h77;
        tick("lu_bubble");
        check("lu_bub_valid", 32'(ex_valid), 0);
        check("lu_bub_rw", 32'(ex_reg_write), 0);
        check("lu_hz_off", 32'(hazard_stall), 0);
        no_fwd();
        memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'h55;
        tick("lu_dep");
        check("lu_dep_valid", 32'(ex_valid), 1);
        check("lu_dep_in1", alu_in1, 32'h55);

        // flush beats stall
        no_fwd();
        set_id(1, 1, 2, 9, 1, 2, 0, 4'b0011, 0, 1, 0, 0, 0, 0);
        flush = 1; stall = 1;
        tick("flush_stall");
        check("flush_valid", 32'(ex_valid), 0);
        flush = 0; stall = 0;
        set_id(1, 1, 2, 10, 32'h11, 32'h22, 0, 4'b0111, 0, 1, 0, 0, 0, 0);
        tick("pre_stall");
        stall = 1;
        set_id(1, 3, 4, 12, 32'h99, 32'h88, 0, 4'b1100, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick($sformatf("stall%0d", i));
            check($sformatf("stall%0d_in1", i), alu_in1, 32'h11);
            check($sformatf("stall%0d_rd", i), 32'(ex_rd), 10);
        end
        stall = 0;

        // reset mid-operation between edges
        set_id(1, 1, 2, 13, 32'h31, 32'h32, 0, 4'b0010, 0, 1, 0, 0, 0, 0);
        tick("pre_rst");
        check("pre_rst_valid", 32'(ex_valid), 1);
        @(negedge clk);
        #2;
        rst = 1;
        m_bubble();
        observe("mid_rst");
        check("mid_rst_valid", 32'(ex_valid), 0);
        check("mid_rst_alu", 32'(alu_cntrl), 32'h2);
        @(negedge clk);
        rst = 0;
        tick("post_rst");
        check("post_rst_in1", alu_in1, 32'h31);
        check("post_rst_rd", 32'(ex_rd), 13);

        // randomized traffic through the model
        for (int i = 0; i < 80; i++) begin
            set_id(1'($urandom), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom, $urandom, $urandom, 4'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom), 1'($urandom), 1'($urandom));
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            exmem_reg_write = 1'($urandom);
            exmem_rd = 5'($urandom_range(0, 7));
            exmem_result = $urandom;
            memwb_reg_write = 1'($urandom);
            memwb_rd = 5'($urandom_range(0, 7));
            memwb_result = $urandom;
            tick($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register plus operand-forwarding logic for the five-stage RISC-V core. It captures decoded operands and control from the ID stage and resolves data hazards by forwarding from EX/MEM and MEM/WB. It drives the final `In1`/`In2`/`ALU_Cntrl` values into the ALU. It also detects load-use hazards, inserting a bubble and raising a stall request to the IF/ID stages.

## Interface
- `WIDTH`, default 32, datapath width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_rs1_data`, `id_rs2_data`, `id_imm`  in  WIDTH  register-file reads and sign-extended immediate.
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr`  in  5  register indices.
- `id_alu_cntrl`  in  4  ALU operation code.
- `id_alu_src`  in  1  selects the immediate for `alu_in2`.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`, `id_branch`  in  1  decoded control.
- `stall`  in  1  global freeze (for example, memory wait).
- `flush`  in  1  squash the incoming instruction (taken branch).
- `exmem_reg_write`  in  1  EX/MEM forwarding source.
- `exmem_rd`  in  5  EX/MEM forwarding source.
- `exmem_result`  in  WIDTH  EX/MEM forwarding source.
- `memwb_reg_write`  in  1  MEM/WB forwarding source.
- `memwb_rd`  in  5  MEM/WB forwarding source.
- `memwb_result`  in  WIDTH  MEM/WB forwarding source.
- `ex_valid`  out  1  EX slot holds a real instruction.
- `alu_cntrl`  out  4  to ALU.
- `alu_in1`, `alu_in2`  out  WIDTH  forwarded operands to ALU.
- `ex_store_data`  out  WIDTH  forwarded rs2 value for stores.
- `ex_rd`  out  5  destination register, passed downstream.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_branch`  out  1  registered control flags.
- `hazard_stall`  out  1  load-use stall request to the PC and IF/ID stages.

## Operation
- **Register update rule**, evaluated each cycle in priority order:
  1. `flush` → load a bubble.
  2. `stall` → hold all registered state.
  3. `hazard_stall` → load a bubble.
  4. Otherwise → load all `id_*` fields.
- **Bubble contents:** `ex_valid` = 0, all control flags = 0, `ex_rd` = 0, `alu_cntrl` = ADD (`0010`), data fields = 0.
- **`hazard_stall`** (combinational) = `ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & (ex_rd == id_rs1_addr | ex_rd == id_rs2_addr)`.
  - It compares against rs2 even for I-type instructions; this is conservative and accepted.
- **Forward select**, computed per source operand (rs1, rs2) against the registered rs addresses:
  - EX/MEM match: `exmem_reg_write & exmem_rd != 0 & exmem_rd == rs` → `exmem_result`.
  - Else MEM/WB match, same rule → `memwb_result`.
  - Else the registered register-file data.
  - EX/MEM always beats MEM/WB. Register x0 is never forwarded.
- **Operand assignment:**
  - `alu_in1` = forwarded rs1.
  - `alu_in2` = `id_alu_src` (as registered) ? registered imm : forwarded rs2.
  - `ex_store_data` = forwarded rs2, independent of `alu_src`.
- **Forwarding while invalid:** forwarding is applied even when `ex_valid` = 0. The operand values are harmless because all control flags are 0.

## Timing
- **Latency:** fields sampled at edge N appear on the outputs after edge N.
- **Forwarding path:** combinational within the EX cycle, registered state → `alu_in*`. There is no added latency.
- **`hazard_stall` path:** combinational from registered EX state plus the live `id_*` addresses. It is asserted for exactly one cycle per load-use pair, because the bubble clears `ex_mem_read` on the next edge.
- **Reset:** the asynchronous `rst` clears every register immediately.
  - While reset is held, all outputs are 0 except `alu_cntrl` = `0010`.
  - Together with the forward-select rule, this means `alu_in1` = `alu_in2` = `ex_store_data` = 0 and `hazard_stall` = 0.
- **Reset mid-stall:** the register contents are discarded, and the stall has no effect afterwards.
- **Simultaneous events:**
  - `flush` + `stall`: flush wins.
  - `stall` + `hazard_stall`: the register is held, and `hazard_stall` stays asserted until the stall drops.

## Structure
- **Shared package `pipe_pkg`:**
  - ALU opcode constants: AND `0000`, OR `0001`, ADD `0010`, XOR `0011`, SUB `0110`, SLT `0111`, NOR `1100`.
  - Forward-select encoding: `00` reg, `01` MEM/WB, `10` EX/MEM.
  - The bubble control constant.
- **Sub-module `forward_unit`:**
  - Purely combinational.
  - Inputs: the two rs addresses plus the EX/MEM and MEM/WB write-back info.
  - Outputs: the two 2-bit selects.
  - It is reused by the branch-compare logic in ID.

## Test plan
- **Basic capture:** no hazards, ID issues `add x3,x1,x2` with rs1 = 5 and rs2 = 7 → next cycle `alu_in1` = 5, `alu_in2` = 7, `alu_cntrl` = `0010`, `ex_rd` = 3, `ex_valid` = 1.
- **Forwarding priority:** EX rs1 = x4, with EX/MEM writing x4 = 0xAA and MEM/WB writing x4 = 0xBB → `alu_in1` = 0xAA. Then drop EX/MEM write → `alu_in1` = 0xBB.
- **x0 guard:** EX/MEM writes x0 = 0xFFFF_FFFF while EX rs1 = x0 and register data = 0 → `alu_in1` = 0.
- **Load-use:** EX holds `lw x5` and ID presents rs1 = x5 → `hazard_stall` = 1 for one cycle, then a bubble enters EX (`ex_valid` = 0, `ex_reg_write` = 0). The following cycle the dependent instruction enters with MEM/WB forwarding of x5.
- **Flush vs stall:** `flush` = `stall` = 1 with a valid ID instruction → EX becomes a bubble. `stall` alone for 3 cycles → outputs unchanged across all 3 cycles.
- **Reset mid-operation:** assert `rst` asynchronously between edges while `ex_valid` = 1 → outputs immediately reach the reset values. After release, the first edge loads the ID data.
